// File: rtl/htv_satd_accumulator_pkg.sv
// Shared definitions for the SATD accumulator slice.
//   cw(length)       signed coefficient width from ht_vertical
//   psum_w(length)   width of one beat's sum of eight magnitudes
//   sw(length,nblk)  width of the accumulated SATD result
//   phase_t          beat phase / sel encoding (sum half, difference half)
//   nblk_legal(nblk) accepted block counts per result
package htv_satd_accumulator_pkg;

  typedef enum logic {
    PH_SUM = 1'b0,
    PH_DIF = 1'b1
  } phase_t;

  function automatic int unsigned cw(input int unsigned length);
    return length + 5;
  endfunction

  function automatic int unsigned psum_w(input int unsigned length);
    return length + 8;
  endfunction

  function automatic int unsigned sw(input int unsigned length, input int unsigned nblk);
    return length + 9 + $clog2(nblk);
  endfunction

  function automatic bit nblk_legal(input int unsigned nblk);
    return (nblk == 1) || (nblk == 2) || (nblk == 4) || (nblk == 16);
  endfunction

endpackage

// File: rtl/htv_satd_accumulator_if.sv
// Bus between ht_vertical / cost comparator and the SATD accumulator.
//   sel        phase request to ht_vertical (0 sum half, 1 difference half)
//   in_valid / in_ready, htv_0..htv_7   coefficient beat handshake
//   out_valid / out_ready, satd         result handshake
// master: the environment side (producer of beats, consumer of results)
// slave : the accumulator
interface htv_satd_accumulator_if
  import htv_satd_accumulator_pkg::*;
#(
  parameter int unsigned LENGTH = 10,
  parameter int unsigned NBLK   = 1
);
  localparam int unsigned CW = cw(LENGTH);
  localparam int unsigned SW = sw(LENGTH, NBLK);

  logic                 sel;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [CW-1:0] htv_0, htv_1, htv_2, htv_3, htv_4, htv_5, htv_6, htv_7;
  logic                 out_valid;
  logic                 out_ready;
  logic        [SW-1:0] satd;

  modport master (
    input  sel, in_ready, out_valid, satd,
    output in_valid, htv_0, htv_1, htv_2, htv_3, htv_4, htv_5, htv_6, htv_7, out_ready
  );

  modport slave (
    output sel, in_ready, out_valid, satd,
    input  in_valid, htv_0, htv_1, htv_2, htv_3, htv_4, htv_5, htv_6, htv_7, out_ready
  );

endinterface

// File: rtl/htv_satd_accumulator_abs_sum8.sv
// abs_sum8: combinational sum of the magnitudes of eight signed coefficients.
//   x[0..7]  in  CW-bit signed coefficients
//   sum      out LENGTH+8-bit unsigned sum of |x[i]|
// Magnitudes are formed on a one-bit sign extension so the most negative
// coefficient maps to its true positive value. Balanced 3-level adder tree.
module abs_sum8
  import htv_satd_accumulator_pkg::*;
#(
  parameter  int unsigned LENGTH = 10,
  localparam int unsigned CW     = cw(LENGTH),
  localparam int unsigned PW     = psum_w(LENGTH)
) (
  input  logic signed [CW-1:0] x [8],
  output logic        [PW-1:0] sum
);

  logic signed [CW:0]   ext  [8];
  logic        [CW:0]   absv [8];
  logic        [PW-1:0] mag  [8];
  logic        [PW-1:0] l1   [4];
  logic        [PW-1:0] l2   [2];

  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      ext[i]  = {x[i][CW-1], x[i]};
      absv[i] = ext[i][CW] ? $unsigned(-ext[i]) : $unsigned(ext[i]);
      mag[i]  = PW'(absv[i]);
    end
    for (int unsigned j = 0; j < 4; j++) begin
      l1[j] = mag[2*j] + mag[2*j+1];
    end
    for (int unsigned k = 0; k < 2; k++) begin
      l2[k] = l1[2*k] + l1[2*k+1];
    end
    sum = l2[0] + l2[1];
  end

endmodule

// File: rtl/htv_satd_accumulator.sv
// htv_satd_accumulator: consumes ht_vertical output two beats per 4x4 block
// (sel=0 sum half, sel=1 difference half), forms (|sum0|+|sum1|+1)>>1 per
// block and accumulates NBLK blocks into one SATD result.
//   clk, rst  clock and synchronous active-high reset
//   bus       slave side of htv_satd_accumulator_if (sel, beat handshake
//             with htv_0..htv_7, result handshake with satd)
// Pipeline: stage 1 registers the beat's magnitude sum at the accepting
// edge, stage 2 folds it into the block/accumulator registers and loads the
// result on the group's last beat (out_valid two cycles after acceptance).
module htv_satd_accumulator
  import htv_satd_accumulator_pkg::*;
#(
  parameter int unsigned LENGTH = 10,
  parameter int unsigned NBLK   = 1
) (
  input logic clk,
  input logic rst,
  htv_satd_accumulator_if.slave bus
);

  localparam int unsigned CW   = cw(LENGTH);
  localparam int unsigned PW   = psum_w(LENGTH);
  localparam int unsigned SW   = sw(LENGTH, NBLK);
  localparam int unsigned BLKW = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam logic [BLKW-1:0] BLK_LAST = BLKW'(NBLK - 1);

  if (!nblk_legal(NBLK)) begin : g_bad_nblk
    $error("htv_satd_accumulator: NBLK must be 1, 2, 4 or 16");
  end

  phase_t               phase_q, phase_d;
  logic      [BLKW-1:0] blk_q, blk_d;
  logic                 in_ready;
  logic                 accept;
  logic                 last_beat;
  logic signed [CW-1:0] htv [8];
  logic      [PW-1:0]   p_comb;

  logic                 s1_valid;
  phase_t               s1_phase;
  logic                 s1_last;
  logic                 s1_first;
  logic      [PW-1:0]   s1_p;

  logic      [PW-1:0]   b_q;
  logic      [PW:0]     pair_sum;
  logic      [PW-1:0]   blk_val;
  logic      [SW-1:0]   acc_q, acc_next;
  logic      [SW-1:0]   satd_q;
  logic                 out_valid_q;

  assign htv[0] = bus.htv_0;
  assign htv[1] = bus.htv_1;
  assign htv[2] = bus.htv_2;
  assign htv[3] = bus.htv_3;
  assign htv[4] = bus.htv_4;
  assign htv[5] = bus.htv_5;
  assign htv[6] = bus.htv_6;
  assign htv[7] = bus.htv_7;

  // Only a pending, unaccepted result stalls input; a group is at least two
  // beats, so stage 1 can never hold a last beat while a result is pending.
  assign in_ready  = ~(out_valid_q & ~bus.out_ready);
  assign accept    = bus.in_valid & in_ready;
  assign last_beat = (phase_q == PH_DIF) && (blk_q == BLK_LAST);

  assign bus.sel       = phase_q;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.satd      = satd_q;

  abs_sum8 #(.LENGTH(LENGTH)) u_abs_sum8 (
    .x   (htv),
    .sum (p_comb)
  );

  // Phase / block counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_SUM;
      blk_q   <= '0;
    end else begin
      phase_q <= phase_d;
      blk_q   <= blk_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    blk_d   = blk_q;
    if (accept) begin
      phase_d = (phase_q == PH_SUM) ? PH_DIF : PH_SUM;
      if (phase_q == PH_DIF) begin
        blk_d = (blk_q == BLK_LAST) ? '0 : blk_q + 1'b1;
      end
    end
  end

  // Stage 1: beat magnitude sum plus its position within the group
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_phase <= PH_SUM;
      s1_last  <= 1'b0;
      s1_first <= 1'b0;
      s1_p     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_phase <= phase_q;
        s1_last  <= last_beat;
        s1_first <= (blk_q == '0);
        s1_p     <= p_comb;
      end
    end
  end

  // Stage 2: block rounding and group accumulation
  always_comb begin
    pair_sum = {1'b0, b_q} + {1'b0, s1_p} + (PW+1)'(1);
    blk_val  = PW'(pair_sum >> 1);
    acc_next = (s1_first ? '0 : acc_q) + SW'(blk_val);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_q         <= '0;
      acc_q       <= '0;
      satd_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (s1_valid) begin
        if (s1_phase == PH_SUM) begin
          b_q <= s1_p;
        end else begin
          acc_q <= acc_next;
        end
      end
      // A completing result wins over a same-cycle consume.
      if (s1_valid && (s1_phase == PH_DIF) && s1_last) begin
        satd_q      <= acc_next;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_htv_satd_accumulator.sv
module tb_htv_satd_accumulator;

  logic clk;
  logic rst;
  int   checks;
  int   passes;

  logic        snap1_ov;
  logic [18:0] snap1_satd;
  int          ov4_cnt;

  htv_satd_accumulator_if #(.LENGTH(10), .NBLK(1)) b1 ();
  htv_satd_accumulator_if #(.LENGTH(10), .NBLK(4)) b4 ();

  htv_satd_accumulator #(.LENGTH(10), .NBLK(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  htv_satd_accumulator #(.LENGTH(10), .NBLK(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one beat to dut1: htv_0=z, htv_2/4/6=e, htv_1/3/5/7=o.
  task automatic beat1(input int z, input int e, input int o, input logic exp_sel, input string nm);
    bit done;
    done = 1'b0;
    b1.htv_0 = 15'(z); b1.htv_1 = 15'(o); b1.htv_2 = 15'(e); b1.htv_3 = 15'(o);
    b1.htv_4 = 15'(e); b1.htv_5 = 15'(o); b1.htv_6 = 15'(e); b1.htv_7 = 15'(o);
    b1.in_valid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      snap1_ov   = b1.out_valid;
      snap1_satd = b1.satd;
      if (b1.in_ready === 1'b1) begin
        done = 1'b1;
        checks++;
        if (b1.sel !== exp_sel) $display("FAIL %s_sel: got %b want %b", nm, b1.sel, exp_sel);
        else passes++;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++;
      $display("FAIL %s_accept: in_ready never 1 within 50 cycles", nm);
    end
  endtask

  task automatic beat4(input int z, input int e, input int o, input logic exp_sel, input string nm);
    bit done;
    done = 1'b0;
    b4.htv_0 = 15'(z); b4.htv_1 = 15'(o); b4.htv_2 = 15'(e); b4.htv_3 = 15'(o);
    b4.htv_4 = 15'(e); b4.htv_5 = 15'(o); b4.htv_6 = 15'(e); b4.htv_7 = 15'(o);
    b4.in_valid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (b4.out_valid === 1'b1) ov4_cnt++;
      if (b4.in_ready === 1'b1) begin
        done = 1'b1;
        checks++;
        if (b4.sel !== exp_sel) $display("FAIL %s_sel: got %b want %b", nm, b4.sel, exp_sel);
        else passes++;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++;
      $display("FAIL %s_accept: in_ready never 1 within 50 cycles", nm);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b1.in_valid = 1'b0; b1.out_ready = 1'b1;
    b4.in_valid = 1'b0; b4.out_ready = 1'b1;
    b1.htv_0 = '0; b1.htv_1 = '0; b1.htv_2 = '0; b1.htv_3 = '0;
    b1.htv_4 = '0; b1.htv_5 = '0; b1.htv_6 = '0; b1.htv_7 = '0;
    b4.htv_0 = '0; b4.htv_1 = '0; b4.htv_2 = '0; b4.htv_3 = '0;
    b4.htv_4 = '0; b4.htv_5 = '0; b4.htv_6 = '0; b4.htv_7 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (b1.sel !== 1'b0) $display("FAIL rst_sel: got %b want 0", b1.sel); else passes++;
    checks++; if (b1.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", b1.out_valid); else passes++;
    checks++; if (b1.satd !== 19'd0) $display("FAIL rst_satd: got %0d want 0", b1.satd); else passes++;
    checks++; if (b1.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", b1.in_ready); else passes++;
    checks++; if (b4.out_valid !== 1'b0) $display("FAIL rst4_out_valid: got %b want 0", b4.out_valid); else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    beat1(5, 5, 5, 1'b0, "t1_b0");
    beat1(5, 5, 5, 1'b1, "t1_b1");
    b1.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (b1.out_valid !== 1'b0) $display("FAIL t1_early: out_valid %b want 0 at t+1", b1.out_valid); else passes++;
    checks++; if (b1.sel !== 1'b0) $display("FAIL t1_sel_wrap: got %b want 0", b1.sel); else passes++;
    @(negedge clk);
    checks++; if (b1.out_valid !== 1'b1) $display("FAIL t1_valid: out_valid %b want 1 at t+2", b1.out_valid); else passes++;
    checks++; if (b1.satd !== 19'd40) $display("FAIL t1_satd: got %0d want 40", b1.satd); else passes++;
    @(negedge clk);
    checks++; if (b1.out_valid !== 1'b0) $display("FAIL t1_pulse: out_valid %b want 0", b1.out_valid); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    beat1(1, 0, 0, 1'b0, "t2a_b0");
    beat1(0, 0, 0, 1'b1, "t2a_b1");
    beat1(-3, -3, 3, 1'b0, "t2b_b0");
    beat1(-3, -3, 3, 1'b1, "t2b_b1");
    b1.in_valid = 1'b0;
    checks++; if (snap1_ov !== 1'b1) $display("FAIL t2a_valid: out_valid %b want 1", snap1_ov); else passes++;
    checks++; if (snap1_satd !== 19'd1) $display("FAIL t2a_satd: got %0d want 1", snap1_satd); else passes++;
    @(negedge clk);
    checks++; if (b1.out_valid !== 1'b0) $display("FAIL t2b_early: out_valid %b want 0", b1.out_valid); else passes++;
    @(negedge clk);
    checks++; if (b1.out_valid !== 1'b1) $display("FAIL t2b_valid: out_valid %b want 1", b1.out_valid); else passes++;
    checks++; if (b1.satd !== 19'd24) $display("FAIL t2b_satd: got %0d want 24", b1.satd); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_extreme();
    beat1(-16384, -16384, -16384, 1'b0, "t3_b0");
    beat1(-16384, -16384, -16384, 1'b1, "t3_b1");
    b1.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (b1.out_valid !== 1'b1) $display("FAIL t3_valid: out_valid %b want 1", b1.out_valid); else passes++;
    checks++; if (b1.satd !== 19'd131072) $display("FAIL t3_satd: got %0d want 131072", b1.satd); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_nblk4();
    int seen;
    seen = 0;
    ov4_cnt = 0;
    beat4(5, 5, 5, 1'b0, "t4_0");
    beat4(5, 5, 5, 1'b1, "t4_1");
    beat4(-3, -3, 3, 1'b0, "t4_2");
    beat4(-3, -3, 3, 1'b1, "t4_3");
    beat4(1, 0, 0, 1'b0, "t4_4");
    beat4(0, 0, 0, 1'b1, "t4_5");
    beat4(0, 0, 0, 1'b0, "t4_6");
    beat4(0, 0, 0, 1'b1, "t4_7");
    b4.in_valid = 1'b0;
    checks++; if (ov4_cnt != 0) $display("FAIL t4_no_early: out_valid seen %0d times during group, want 0", ov4_cnt); else passes++;
    @(negedge clk);
    if (b4.out_valid === 1'b1) seen++;
    @(negedge clk);
    if (b4.out_valid === 1'b1) seen++;
    checks++; if (b4.out_valid !== 1'b1) $display("FAIL t4_valid: out_valid %b want 1", b4.out_valid); else passes++;
    checks++; if (b4.satd !== 21'd65) $display("FAIL t4_satd: got %0d want 65", b4.satd); else passes++;
    repeat (3) begin
      @(negedge clk);
      if (b4.out_valid === 1'b1) seen++;
    end
    checks++; if (seen != 1) $display("FAIL t4_pulse: out_valid cycles %0d want 1", seen); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    b1.out_ready = 1'b0;
    beat1(5, 5, 5, 1'b0, "t5a_b0");
    beat1(5, 5, 5, 1'b1, "t5a_b1");
    beat1(-3, -3, 3, 1'b0, "t5b_b0");
    b1.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (b1.out_valid !== 1'b1) $display("FAIL t5_hold_valid[%0d]: got %b want 1", c, b1.out_valid); else passes++;
      checks++; if (b1.in_ready !== 1'b0) $display("FAIL t5_in_ready[%0d]: got %b want 0", c, b1.in_ready); else passes++;
      checks++; if (b1.satd !== 19'd40) $display("FAIL t5_hold_satd[%0d]: got %0d want 40", c, b1.satd); else passes++;
      checks++; if (b1.sel !== 1'b1) $display("FAIL t5_hold_sel[%0d]: got %b want 1", c, b1.sel); else passes++;
    end
    @(posedge clk); #1;
    b1.out_ready = 1'b1;
    beat1(-3, -3, 3, 1'b1, "t5b_b1");
    b1.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (b1.out_valid !== 1'b0) $display("FAIL t5_drop: out_valid %b want 0", b1.out_valid); else passes++;
    @(negedge clk);
    checks++; if (b1.out_valid !== 1'b1) $display("FAIL t5b_valid: out_valid %b want 1", b1.out_valid); else passes++;
    checks++; if (b1.satd !== 19'd24) $display("FAIL t5b_satd: got %0d want 24", b1.satd); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    beat1(7, 7, 7, 1'b0, "t6_pre");
    b1.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (b1.sel !== 1'b0) $display("FAIL t6_sel: got %b want 0", b1.sel); else passes++;
    checks++; if (b1.out_valid !== 1'b0) $display("FAIL t6_out_valid: got %b want 0", b1.out_valid); else passes++;
    @(posedge clk); #1;
    beat1(5, 5, 5, 1'b0, "t6_b0");
    beat1(5, 5, 5, 1'b1, "t6_b1");
    b1.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (b1.out_valid !== 1'b1) $display("FAIL t6_valid: out_valid %b want 1", b1.out_valid); else passes++;
    checks++; if (b1.satd !== 19'd40) $display("FAIL t6_satd: got %0d want 40", b1.satd); else passes++;
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_extreme();
    test_nblk4();
    test_stall();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
